// File: rtl/dmem_axi_wr.sv
// Word-organised data memory behind a single-outstanding AXI INCR write port.
// Bad bursts are still fully accepted, and the bad burst gets an SLVERR response.
module dmem_axi_wr #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ADDR_W-1:0]              awaddr,
  input  logic [7:0]                     awlen,
  input  logic [2:0]                     awsize,
  input  logic [1:0]                     awburst,
  input  logic                           wvalid,
  output logic                           wready,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [DATA_W/8-1:0]            wstrb,
  input  logic                           wlast,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [1:0]                     bresp,
  input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]              dbg_rdata
);
  localparam int STRB_W   = DATA_W / 8;
  localparam int SIZE_LOG = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t             r_state;
  logic               r_awready;
  logic               r_wready;
  logic               r_bvalid;
  logic [1:0]         r_bresp;
  logic [8:0]         r_beat;
  logic [7:0]         r_len;
  logic [IDX_W-1:0]   r_base;
  logic               r_err;
  logic [DATA_W-1:0]  r_mem [DEPTH_WORDS];

  logic [ADDR_W:0]    w_end;
  logic               w_aw_err;
  logic               w_beat;
  logic               w_in_range;
  logic               w_wr_en;
  logic               w_err_nxt;
  logic [IDX_W-1:0]   w_widx;

  // One past the last word touched by the requested burst, widened so it cannot overflow
  assign w_end = {1'b0, awaddr >> SIZE_LOG} + (ADDR_W+1)'(awlen) + (ADDR_W+1)'(1);
  assign w_aw_err = (awburst != 2'b01) || (awsize != 3'(SIZE_LOG)) ||
                    (awaddr[SIZE_LOG-1:0] != '0) || (w_end > (ADDR_W+1)'(DEPTH_WORDS));

  assign w_beat     = wvalid & r_wready;
  assign w_in_range = (r_beat <= {1'b0, r_len});
  assign w_wr_en    = w_beat & ~r_err & w_in_range;
  assign w_widx     = r_base + IDX_W'(r_beat[7:0]);
  assign w_err_nxt  = r_err | ~w_in_range |
                      (wlast & (r_beat < {1'b0, r_len})) |
                      (~wlast & (r_beat == {1'b0, r_len}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_beat    <= '0;
      r_len     <= '0;
      r_base    <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (awvalid && r_awready) begin
            r_len     <= awlen;
            r_base    <= awaddr[SIZE_LOG +: IDX_W];
            r_err     <= w_aw_err;
            r_beat    <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_err <= w_err_nxt;
            if (r_beat != 9'd256) r_beat <= r_beat + 9'd1;
            if (wlast) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_err_nxt ? 2'b10 : 2'b00;
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_awready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) r_mem[w_widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign awready   = r_awready & ~rst;
  assign wready    = r_wready;
  assign bvalid    = r_bvalid;
  assign bresp     = r_bresp;
  assign dbg_rdata = r_mem[dbg_addr];

endmodule

// File: tb/tb_dmem_axi_wr.sv
// Randomised bench for dmem_axi_wr: directed scenarios plus random bursts
// checked against a burst-level memory/response model.
module tb_dmem_axi_wr;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic [9:0]  dbg_addr = '0;
  logic [31:0] dbg_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_mem [1024];
  logic [31:0] q_data [$];
  logic [3:0]  q_strb [$];

  dmem_axi_wr dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic send_aw(input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    int cnt = 0;
    @(negedge clk);
    awvalid = 1'b1; awaddr = a; awlen = l; awsize = s; awburst = b;
    while (!awready && cnt < 100) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (!awready) begin
      n_bad++; $display("FAIL aw_handshake: awready=%0b required 1", awready);
      awvalid = 1'b0; return;
    end
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] st, input logic lst);
    int cnt = 0;
    @(negedge clk);
    wvalid = 1'b1; wdata = d; wstrb = st; wlast = lst;
    while (!wready && cnt < 100) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (!wready) begin
      n_bad++; $display("FAIL w_handshake: wready=%0b required 1", wready);
      wvalid = 1'b0; wlast = 1'b0; return;
    end
    @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] r);
    int cnt = 0;
    @(negedge clk);
    bready = 1'b1;
    while (!bvalid && cnt < 100) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (!bvalid) begin
      n_bad++; $display("FAIL b_handshake: bvalid=%0b required 1", bvalid);
      bready = 1'b0; r = 2'bxx; return;
    end
    r = bresp;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  // Burst-level model: header legality decides writes; OKAY only if wlast lands exactly on beat awlen
  task automatic model_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, input int nb, output logic [1:0] exp);
    longint base = longint'(a) / 4;
    bit ok = (b == 2'b01) && (s == 3'd2) && (a[1:0] == 2'b00) && (base + l + 1 <= 1024);
    if (ok)
      for (int n = 0; n < nb && n <= int'(l); n++)
        for (int k = 0; k < 4; k++)
          if (q_strb[n][k]) m_mem[base + n][k*8 +: 8] = q_data[n][k*8 +: 8];
    exp = (ok && nb == int'(l) + 1) ? 2'b00 : 2'b10;
  endtask

  task automatic run_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input int nb, output logic [1:0] r);
    send_aw(a, l, s, b);
    for (int n = 0; n < nb; n++) send_w(q_data[n], q_strb[n], n == nb - 1);
    get_b(r);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({awready, wready, bvalid, bresp} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b required 00000", {awready, wready, bvalid, bresp});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (awready !== 1'b1) begin n_bad++; $display("FAIL reset_release_awready: got %b required 1", awready); end
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (wready !== 1'b0) begin n_bad++; $display("FAIL idle_wready: got %b required 0", wready); end
    end
    wvalid = 1'b0;
  endtask

  task automatic test_init();
    logic [1:0] r, e;
    for (int blk = 0; blk < 4; blk++) begin
      q_data.delete(); q_strb.delete();
      for (int n = 0; n < 256; n++) begin q_data.push_back($urandom); q_strb.push_back(4'hF); end
      for (int n = 0; n < 256; n++) m_mem[blk*256 + n] = q_data[n];
      run_burst(32'(blk * 1024), 8'd255, 3'd2, 2'b01, 256, r);
      n_cmp++;
      if (r !== 2'b00) begin n_bad++; $display("FAIL init_bresp: got %b required 00", r); end
    end
    for (int i = 0; i < 1024; i += 37) begin
      dbg_addr = 10'(i); #1;
      n_cmp++;
      if (dbg_rdata !== m_mem[i]) begin n_bad++; $display("FAIL init_word %0d: got %h required %h", i, dbg_rdata, m_mem[i]); end
    end
  endtask

  task automatic test_incr_burst();
    logic [1:0] r, e;
    q_data.delete(); q_strb.delete();
    for (int n = 0; n < 8; n++) begin q_data.push_back(32'h1000 + 32'(n)); q_strb.push_back(4'hF); end
    model_burst(32'h40, 8'd7, 3'd2, 2'b01, 8, e);
    run_burst(32'h40, 8'd7, 3'd2, 2'b01, 8, r);
    n_cmp++;
    if (r !== 2'b00) begin n_bad++; $display("FAIL incr_bresp: got %b required 00", r); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 10'(16 + i); #1;
      n_cmp++;
      if (dbg_rdata !== 32'h1000 + 32'(i)) begin
        n_bad++; $display("FAIL incr_word %0d: got %h required %h", 16 + i, dbg_rdata, 32'h1000 + 32'(i));
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r, e;
    q_data = '{32'h1111_1111}; q_strb = '{4'hF};
    model_burst(32'h40, 8'd0, 3'd2, 2'b01, 1, e);
    run_burst(32'h40, 8'd0, 3'd2, 2'b01, 1, r);
    q_data = '{32'hAABB_CCDD}; q_strb = '{4'b0101};
    model_burst(32'h40, 8'd0, 3'd2, 2'b01, 1, e);
    run_burst(32'h40, 8'd0, 3'd2, 2'b01, 1, r);
    n_cmp++;
    if (r !== 2'b00) begin n_bad++; $display("FAIL strobe_bresp: got %b required 00", r); end
    dbg_addr = 10'd16; #1;
    n_cmp++;
    if (dbg_rdata !== 32'h11BB_11DD) begin n_bad++; $display("FAIL strobe_word: got %h required 11bb11dd", dbg_rdata); end
  endtask

  task automatic test_oob();
    logic [1:0] r, e;
    q_data.delete(); q_strb.delete();
    for (int n = 0; n < 4; n++) begin q_data.push_back($urandom); q_strb.push_back(4'hF); end
    model_burst(32'((1024 - 2) * 4), 8'd3, 3'd2, 2'b01, 4, e);
    run_burst(32'((1024 - 2) * 4), 8'd3, 3'd2, 2'b01, 4, r);
    n_cmp++;
    if (r !== 2'b10) begin n_bad++; $display("FAIL oob_bresp: got %b required 10", r); end
    for (int i = 1020; i < 1024; i++) begin
      dbg_addr = 10'(i); #1;
      n_cmp++;
      if (dbg_rdata !== m_mem[i]) begin n_bad++; $display("FAIL oob_word %0d: got %h required %h", i, dbg_rdata, m_mem[i]); end
    end
  endtask

  task automatic test_early_wlast();
    logic [1:0] r, e;
    logic [31:0] d0, d1;
    q_data.delete(); q_strb.delete();
    d0 = $urandom; d1 = $urandom;
    q_data = '{d0, d1}; q_strb = '{4'hF, 4'hF};
    model_burst(32'h100, 8'd3, 3'd2, 2'b01, 2, e);
    run_burst(32'h100, 8'd3, 3'd2, 2'b01, 2, r);
    n_cmp++;
    if (r !== 2'b10) begin n_bad++; $display("FAIL early_bresp: got %b required 10", r); end
    for (int i = 64; i < 68; i++) begin
      dbg_addr = 10'(i); #1;
      n_cmp++;
      if (dbg_rdata !== (i == 64 ? d0 : i == 65 ? d1 : m_mem[i])) begin
        n_bad++; $display("FAIL early_word %0d: got %h required %h", i, dbg_rdata, m_mem[i]);
      end
    end
    q_data = '{32'h5A5A_0001}; q_strb = '{4'hF};
    model_burst(32'h104, 8'd0, 3'd2, 2'b01, 1, e);
    run_burst(32'h104, 8'd0, 3'd2, 2'b01, 1, r);
    n_cmp++;
    if (r !== 2'b00) begin n_bad++; $display("FAIL early_next_bresp: got %b required 00", r); end
  endtask

  task automatic test_bready_stall();
    logic [1:0] e;
    q_data = '{32'hC0DE_0032}; q_strb = '{4'hF};
    model_burst(32'h80, 8'd0, 3'd2, 2'b01, 1, e);
    send_aw(32'h80, 8'd0, 3'd2, 2'b01);
    send_w(32'hC0DE_0032, 4'hF, 1'b1);
    n_cmp++;
    if (bvalid !== 1'b1) begin n_bad++; $display("FAIL stall_bvalid_latency: got %b required 1", bvalid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bvalid, bresp, awready} !== 4'b1000) begin
        n_bad++; $display("FAIL stall_hold cycle %0d: bvalid,bresp,awready=%b required 1000", i, {bvalid, bresp, awready});
      end
    end
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    n_cmp++;
    if ({bvalid, awready} !== 2'b01) begin
      n_bad++; $display("FAIL stall_release: bvalid,awready=%b required 01", {bvalid, awready});
    end
    dbg_addr = 10'd32; #1;
    n_cmp++;
    if (dbg_rdata !== 32'hC0DE_0032) begin n_bad++; $display("FAIL stall_word: got %h required c0de0032", dbg_rdata); end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] r, e;
    int seen = 0;
    q_data.delete(); q_strb.delete();
    for (int n = 0; n < 3; n++) begin q_data.push_back($urandom); q_strb.push_back(4'hF); end
    model_burst(32'h200, 8'd7, 3'd2, 2'b01, 3, e);
    send_aw(32'h200, 8'd7, 3'd2, 2'b01);
    for (int n = 0; n < 3; n++) send_w(q_data[n], 4'hF, 1'b0);
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'hBAD0_0003; wstrb = 4'hF;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({awready, wready, bvalid, bresp} !== 5'b0) begin
      n_bad++; $display("FAIL midrst_outputs: got %b required 00000", {awready, wready, bvalid, bresp});
    end
    @(negedge clk); rst = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (bvalid) seen++; end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL midrst_no_bresp: bvalid cycles %0d required 0", seen); end
    for (int i = 128; i < 136; i++) begin
      dbg_addr = 10'(i); #1;
      n_cmp++;
      if (dbg_rdata !== m_mem[i]) begin n_bad++; $display("FAIL midrst_word %0d: got %h required %h", i, dbg_rdata, m_mem[i]); end
    end
    q_data.delete(); q_strb.delete();
    for (int n = 0; n < 8; n++) begin q_data.push_back($urandom); q_strb.push_back(4'hF); end
    model_burst(32'h200, 8'd7, 3'd2, 2'b01, 8, e);
    run_burst(32'h200, 8'd7, 3'd2, 2'b01, 8, r);
    n_cmp++;
    if (r !== 2'b00) begin n_bad++; $display("FAIL midrst_next_bresp: got %b required 00", r); end
  endtask

  task automatic test_random();
    logic [1:0] r, e, bt;
    logic [2:0] sz;
    logic [31:0] a;
    logic [7:0] l;
    int w, nb, kind, lo, hi;
    for (int it = 0; it < 40; it++) begin
      l = 8'($urandom_range(0, 15));
      w = $urandom_range(0, 1023 - int'(l));
      a = 32'(w * 4); bt = 2'b01; sz = 3'd2; nb = int'(l) + 1;
      kind = $urandom_range(0, 7);
      case (kind)
        0: bt = (($urandom & 1) != 0) ? 2'b00 : 2'b10;
        1: sz = 3'($urandom_range(0, 1));
        2: a = a + 32'($urandom_range(1, 3));
        3: begin w = 1024 - int'(l) + $urandom_range(0, 2); a = 32'(w * 4); end
        4: if (l > 0) nb = $urandom_range(1, int'(l));
        5: nb = int'(l) + 2 + $urandom_range(0, 1);
        default: ;
      endcase
      q_data.delete(); q_strb.delete();
      for (int n = 0; n < nb; n++) begin q_data.push_back($urandom); q_strb.push_back(4'($urandom)); end
      model_burst(a, l, sz, bt, nb, e);
      run_burst(a, l, sz, bt, nb, r);
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL rand_bresp it %0d kind %0d: got %b required %b", it, kind, r, e); end
      lo = (w > 0) ? w - 1 : 0;
      hi = (w + int'(l) + 2 < 1023) ? w + int'(l) + 2 : 1023;
      for (int i = lo; i <= hi; i++) begin
        dbg_addr = 10'(i); #1;
        n_cmp++;
        if (dbg_rdata !== m_mem[i]) begin
          n_bad++; $display("FAIL rand_word it %0d word %0d: got %h required %h", it, i, dbg_rdata, m_mem[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_incr_burst();
    test_strobe();
    test_oob();
    test_early_wlast();
    test_bready_stall();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_axi_wr.md
DMEM_AXI_WR -- requirements
Module: dmem_axi_wr

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width.
REQ-002 Parameter DATA_W, default 32, data beat width; strobe width DATA_W/8.
REQ-003 Parameter DEPTH_WORDS, default 1024, storage size in DATA_W words.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Ports awvalid in 1, awready out 1, awaddr in ADDR_W, awlen in 8, awsize in 3, awburst in 2: AXI write address channel.
REQ-007 Ports wvalid in 1, wready out 1, wdata in DATA_W, wstrb in DATA_W/8, wlast in 1: AXI write data channel.
REQ-008 Ports bvalid out 1, bready in 1, bresp out 2: AXI write response channel.
REQ-009 Ports dbg_addr in clog2(DEPTH_WORDS), dbg_rdata out DATA_W: combinational backdoor word read for benches.

Function
REQ-010 Block SHALL be the AXI write responder (memory side) for a single outstanding INCR burst; no ID, no interleaving.
REQ-011 FSM states SHALL be IDLE, DATA, RESP; reset state IDLE.
REQ-012 IDLE: awready=1, wready=0, bvalid=0; on awvalid&awready latch awaddr, awlen, error flag, clear beat counter, go DATA next cycle.
REQ-013 Error flag SHALL be set when awburst!=INCR(2'b01), awsize!=log2(DATA_W/8), awaddr not word-aligned, or (awaddr/4)+awlen+1 > DEPTH_WORDS.
REQ-014 DATA: awready=0, wready=1; each wvalid&wready cycle is one beat.
REQ-015 Beat n SHALL write word index (awaddr/4)+n, only bytes with wstrb bit set, only when error flag clear and n<=awlen.
REQ-016 Beats with n>awlen SHALL be accepted and discarded, and set the error flag.
REQ-017 wlast on beat n<awlen SHALL set the error flag and end the burst.
REQ-018 Burst SHALL end on the beat carrying wlast; missing wlast on beat awlen keeps DATA open (error flag set) until wlast arrives.
REQ-019 After the ending beat, FSM SHALL enter RESP on the next cycle with bvalid=1, bresp=2'b00 (OKAY) if error flag clear, else 2'b10 (SLVERR).
REQ-020 RESP: bvalid and bresp held stable until bready; on bvalid&bready return to IDLE next cycle; awready first re-asserts the cycle after the handshake.
REQ-021 Minimum latency: AW handshake cycle T, first beat accepted no earlier than T+1, bvalid no earlier than one cycle after last beat.
REQ-022 awvalid in DATA/RESP SHALL be ignored (held off by awready=0); wvalid in IDLE/RESP SHALL be ignored (wready=0).
REQ-023 Beat counter SHALL be 9 bits and saturate at 256; no wrap.
REQ-024 dbg_rdata SHALL reflect mem[dbg_addr], including a write committed on the previous rising edge.
REQ-025 bresp SHALL be 2'b00 whenever bvalid=0.

Reset
REQ-026 rst asserted SHALL immediately force IDLE, awready=1 once released (0 while rst high), wready=0, bvalid=0, bresp=2'b00, counter 0, error flag 0.
REQ-027 Memory contents SHALL NOT be cleared by reset; a burst interrupted by rst keeps already written beats; no B response is issued for it.

Verification
REQ-028 awaddr=0x40, awlen=7, 8 beats data 0x1000+n, wstrb=4'hF, wlast on beat 7 -> bresp OKAY; dbg words 16..23 = 0x1000..0x1007.
REQ-029 awaddr=0x40, awlen=0, wdata=0xAABBCCDD, wstrb=4'b0101 over prior 0x11111111 -> word 16 = 0x11BB11DD, OKAY.
REQ-030 awaddr=(DEPTH_WORDS-2)*4, awlen=3 -> all 4 beats accepted, no memory change, bresp=2'b10.
REQ-031 awlen=3 with wlast on beat 1 -> burst ends after 2 beats, beats 0-1 written, bresp=2'b10, next AW accepted.
REQ-032 bready held low 5 cycles after bvalid -> bvalid/bresp stable, awready=0 throughout, IDLE one cycle after bready.
REQ-033 rst pulsed during beat 3 of awlen=7 burst -> bvalid never asserts, words 0-2 of burst updated, new burst after reset completes OKAY.
